// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver. The line is synchronized, the start bit is
// qualified at its midpoint, and every following bit is sampled one bit period later.
// A byte is published on data with a one-cycle valid pulse when its stop bit is high.
// A low stop bit gives a one-cycle frame_err pulse instead.
module uart_receive #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_index;
    logic [7:0]    shift_reg;
    logic          rx_meta;
    logic          rx_s;
    logic          rearm_wait;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: counters, shift register and the registered data/valid/frame_err outputs.
    // rearm_wait holds the FSM in IDLE after a framing error until the line has been high,
    // so a stuck-low line (break) produces only one frame_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_index  <= '0;
            shift_reg  <= '0;
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            rearm_wait <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt   <= '0;
                    bit_index <= '0;
                    if (rx_s) begin
                        rearm_wait <= 1'b0;
                    end else if (!rearm_wait) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt              <= '0;
                        shift_reg[bit_index] <= rx_s;
                        bit_index            <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            data  <= shift_reg;
                            valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                            rearm_wait <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: drives serial frames (directed and random) into uart_receive.
// Expected pulse times, data and busy windows come from frame timing arithmetic.
// A line transition first seen at clock edge n is sampled by the receiver at rx edges
// n + HALF + k*CPB. Each sample takes effect 2 edges later (synchronizer).
// The stop-bit result is therefore visible after edge n + 2 + HALF + 9*CPB (154 for CPB=16).
module tb_uart_receive;

    localparam int CPB       = 16;
    localparam int HALF      = CPB / 2;
    localparam int PULSE_OFS = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_valid [int];
    bit         exp_err   [int];
    bit         exp_busy  [int];
    logic [7:0] model_data = 8'h00;

    int         valid_count    = 0;
    int         err_count      = 0;
    int         last_valid_cyc = 0;
    logic [7:0] obs_data [$];

    uart_receive #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the index of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Records the busy window and the outcome pulse of a frame whose start is seen at edge n.
    task automatic expectFrame(input int n, input logic [7:0] b, input logic stop_ok);
        for (int c = n + 2; c < n + PULSE_OFS; c++) exp_busy[c] = 1'b1;
        if (stop_ok) exp_valid[n + PULSE_OFS] = b;
        else         exp_err[n + PULSE_OFS]   = 1'b1;
    endtask

    // A start that is high again at mid-start is busy only for the half bit.
    task automatic expectFalseStart(input int n);
        for (int c = n + 2; c < n + 2 + HALF; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic level, input int glitch_at);
        for (int i = 0; i < CPB; i++) begin
            rx = (i == glitch_at) ? ~level : level;
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #3 rst = 1'b1;
        exp_valid.delete();
        exp_err.delete();
        exp_busy.delete();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    // Sends one frame from a falling edge; abort_bit >= 0 resets mid-way through that bit.
    // jitter adds a one-cycle inversion early in each bit, well away from the sample point.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_ok, input int abort_bit,
                                 input bit jitter, output int n);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        n = cyc + 1;
        expectFrame(n, b, stop_ok);
        for (int k = 0; k < 10; k++) begin
            if (k == abort_bit) begin
                rx = bits[k];
                repeat (HALF) @(negedge clk);
                rx = 1'b1;
                doReset();
                return;
            end
            driveBit(bits[k], jitter ? int'($urandom_range(2, HALF - 3)) : -1);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic exp_v;
        if (rst) begin
            model_data = 8'h00;
            checkOutput("rst_valid", valid, 0);
            checkOutput("rst_frame_err", frame_err, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_data", data, 8'h00);
        end else begin
            exp_v = exp_valid.exists(cyc);
            if (exp_v) model_data = exp_valid[cyc];
            checkOutput("valid", valid, exp_v);
            checkOutput("frame_err", frame_err, exp_err.exists(cyc));
            checkOutput("busy", busy, exp_busy.exists(cyc));
            checkOutput("data", data, model_data);
            if (valid) begin
                valid_count++;
                last_valid_cyc = cyc;
                obs_data.push_back(data);
            end
            if (frame_err) err_count++;
        end
    end

    initial begin
        int n;
        int v0;
        int e0;
        int good;
        int bad;
        logic [7:0] b;
        logic stop_ok;

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_busy", busy, 0);
        idle(CPB);

        // Single clean frame.
        v0 = valid_count; e0 = err_count;
        applyStimulus(8'hA5, 1'b1, -1, 1'b0, n);
        idle(2 * CPB);
        checkOutput("a5_pulses", valid_count - v0, 1);
        checkOutput("a5_data", data, 8'hA5);
        checkOutput("a5_latency", last_valid_cyc - n, 154);
        checkOutput("a5_no_err", err_count - e0, 0);

        // Back-to-back frames with no idle gap.
        v0 = valid_count; e0 = err_count;
        applyStimulus(8'h3C, 1'b1, -1, 1'b0, n);
        applyStimulus(8'hFF, 1'b1, -1, 1'b0, n);
        idle(2 * CPB);
        checkOutput("b2b_pulses", valid_count - v0, 2);
        checkOutput("b2b_first", obs_data[obs_data.size() - 2], 8'h3C);
        checkOutput("b2b_second", obs_data[obs_data.size() - 1], 8'hFF);
        checkOutput("b2b_no_err", err_count - e0, 0);

        // Short low glitch: rejected at mid-start.
        v0 = valid_count; e0 = err_count;
        n = cyc + 1;
        expectFalseStart(n);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(2 * CPB);
        checkOutput("glitch_no_valid", valid_count - v0, 0);
        checkOutput("glitch_no_err", err_count - e0, 0);
        checkOutput("glitch_data", data, 8'hFF);

        // Low stop bit.
        v0 = valid_count; e0 = err_count;
        applyStimulus(8'h55, 1'b0, -1, 1'b0, n);
        idle(2 * CPB);
        checkOutput("badstop_err", err_count - e0, 1);
        checkOutput("badstop_no_valid", valid_count - v0, 0);
        checkOutput("badstop_data", data, 8'hFF);

        // Reset in data bit 4, then a clean frame.
        v0 = valid_count; e0 = err_count;
        applyStimulus(8'h0F, 1'b1, 5, 1'b0, n);
        idle(CPB);
        applyStimulus(8'h81, 1'b1, -1, 1'b0, n);
        idle(2 * CPB);
        checkOutput("abort_pulses", valid_count - v0, 1);
        checkOutput("abort_data", data, 8'h81);
        checkOutput("abort_no_err", err_count - e0, 0);

        // Break: line held low for 40 bit times.
        doReset();
        v0 = valid_count; e0 = err_count;
        n = cyc + 1;
        expectFrame(n, 8'h00, 1'b0);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        checkOutput("break_one_err", err_count - e0, 1);
        checkOutput("break_busy", busy, 0);
        checkOutput("break_no_valid", valid_count - v0, 0);
        idle(2 * CPB);
        applyStimulus(8'hC3, 1'b1, -1, 1'b0, n);
        idle(2 * CPB);
        checkOutput("rearm_data", data, 8'hC3);

        // Random frames: random bytes, occasional bad stop bits, in-bit jitter, random gaps.
        v0 = valid_count; e0 = err_count;
        good = 0; bad = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            applyStimulus(b, stop_ok, -1, 1'($urandom_range(0, 1)), n);
            if (stop_ok) begin
                good++;
                idle(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB)));
            end else begin
                bad++;
                idle(CPB + int'($urandom_range(0, CPB)));
            end
        end
        idle(2 * CPB);
        checkOutput("rand_valid_count", valid_count - v0, good);
        checkOutput("rand_err_count", err_count - e0, bad);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
